ttl_7493_sync: RTL and testbench
================================

TTL_7493_SYNC -- requirements
Module: ttl_7493_sync

Interface
REQ-001 SHALL have parameter FILTER, default 1, meaning consecutive identical CLK samples (legal 1..15) required before a TTL clock input level is accepted.
REQ-002 SHALL have parameter CASCADE, default 0, meaning section B is clocked by the internal QA falling transition (1) or by the CKB_N pin (0).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CKA_N  input  1  section A TTL clock, counts on falling edge.
REQ-006 SHALL have port CKB_N  input  1  section B TTL clock, counts on falling edge; ignored when CASCADE=1.
REQ-007 SHALL have ports R0_1, R0_2  input  1 each  count clear, effective only when both high.
REQ-008 SHALL have port QA  output  1  section A divide-by-2 output.
REQ-009 SHALL have ports QB, QC, QD  output  1 each  section B divide-by-8 outputs, QB LSB, QD MSB.

Function
REQ-010 SHALL register CKA_N and CKB_N once per CLK (sample stage) before filtering.
REQ-011 SHALL hold per input an accepted level plus a run counter, width clog2(FILTER+1).
REQ-012 SHALL update the accepted level to the sample once the sample has differed from it for FILTER consecutive samples; a differing run that breaks resets the counter to 0.
REQ-013 SHALL define a falling edge as a 1->0 change of the accepted level; 0->1 changes have no counting effect.
REQ-014 SHALL toggle QA on the CLK edge after a section A falling edge, so total latency from a stable CKA_N change before edge k to the QA change is edge k+FILTER.
REQ-015 SHALL increment {QD,QC,QB} modulo 8 (7 wraps to 0) with the same latency rule on a section B falling edge when CASCADE=0.
REQ-016 SHALL, when CASCADE=1, increment {QD,QC,QB} on the CLK edge after the edge at which QA changed 1->0 (one-cycle ripple delay).
REQ-017 SHALL, in cascade, show 15->0 as QD..QA = 1111, then 1110 for exactly one cycle, then 0000; intermediate ripple states are required, not suppressed.
REQ-018 SHALL treat clear (R0_1 & R0_2) as synchronous: all four Q outputs become 0 on the next CLK edge and stay 0 while clear holds.
REQ-019 SHALL have clear dominate any coincident falling edge on either section; the edge is discarded, not deferred.
REQ-020 SHALL continue filter and accepted-level tracking during clear, so no edge is generated by clear release alone.
REQ-021 SHALL have sections A and B fully independent when CASCADE=0; simultaneous edges on both are both counted in the same cycle.
REQ-022 SHALL ignore pulses on either TTL clock input shorter than FILTER samples (low or high).

Reset
REQ-023 SHALL, on RESET high, asynchronously force QA, QB, QC, QD to 0.
REQ-024 SHALL, on RESET high, set sample registers and accepted levels to 1 (TTL idle high) and run counters to 0.
REQ-025 SHALL count an input held low through reset release as one falling edge, FILTER+1 CLK edges after release.
REQ-026 SHALL abandon any partially filtered transition and pending cascade ripple when RESET asserts mid-operation.

Verification
REQ-027 SHALL cover: FILTER=1, CASCADE=0, 3 CKA_N falling edges, each low 4 CLKs -> QA sequence 1,0,1, each change 1 CLK after the edge is sampled.
REQ-028 SHALL cover: FILTER=1, CASCADE=1, 16 CKA_N falling edges -> QD..QA steps 0..15, one-cycle 1110 after 15, then 0000.
REQ-029 SHALL cover: FILTER=3, CKA_N low pulses of 2 CLKs then 3 CLKs -> first ignored, second toggles QA at edge k+3.
REQ-030 SHALL cover: count at 5 (0101), R0_1=R0_2=1 coincident with CKB_N falling edge -> outputs 0000 next CLK, no increment after release; R0_1 alone high -> no clear.
REQ-031 SHALL cover: RESET pulse mid-count at 1010 with CKA_N low -> outputs 0000 immediately, QA=1 FILTER+1 CLKs after release.
REQ-032 SHALL cover: CASCADE=0, simultaneous falling edges on CKA_N and CKB_N from 0000 -> 0011 after one CLK.

Source files
------------

// File: rtl/ttl_7493_sync.sv
// Clock-synchronous model of the 7493 4-bit ripple counter.
// The TTL clock pins are sampled on CLK and debounced. A falling edge on the
// debounced level advances section A (divide-by-2) or section B (divide-by-8).
// In cascade mode section B is advanced one CLK after QA falls, so the ripple
// states of the original part (for example 1110 between 1111 and 0000) are kept.
module ttl_7493_sync #(
  parameter int FILTER  = 1,  // consecutive identical samples before a level is accepted (1..15)
  parameter int CASCADE = 0   // 1: section B is clocked by the QA fall, 0: by CKB_N
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CKA_N,
  input  logic CKB_N,
  input  logic R0_1,
  input  logic R0_2,
  output logic QA,
  output logic QB,
  output logic QC,
  output logic QD
);

  localparam int CW = $clog2(FILTER + 1);
  // The run counter only has to reach FILTER-1. The FILTER-th differing sample
  // is the one that commits the new level.
  localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

  // Channel 0 is CKA_N and channel 1 is CKB_N. Both use the same filter.
  logic [1:0]         pin;
  logic [1:0]         smp;
  logic [1:0]         acc;
  logic [1:0][CW-1:0] run;
  logic [1:0]         fall;

  logic       clear;
  logic       ripple;
  logic       b_tick;
  logic [2:0] cnt_b;

  assign pin   = {CKB_N, CKA_N};
  assign clear = R0_1 & R0_2;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_ch
      // Sample stage. The pin idles high (TTL) while in reset.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) smp[g] <= 1'b1;
        else       smp[g] <= pin[g];
      end

      // Debounce. The accepted level follows the sample only after FILTER
      // differing samples in a row. Any sample that agrees restarts the run.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          acc[g] <= 1'b1;
          run[g] <= '0;
        end else if (smp[g] != acc[g]) begin
          if (run[g] == LAST) begin
            acc[g] <= smp[g];
            run[g] <= '0;
          end else begin
            run[g] <= run[g] + 1'b1;
          end
        end else begin
          run[g] <= '0;
        end
      end

      // The falling edge is flagged in the same cycle that the accepted level
      // commits 1->0. The counter therefore moves on that CLK edge.
      assign fall[g] = acc[g] & ~smp[g] & (run[g] == LAST);
    end
  endgenerate

  // Section A toggles. Clear wins and drops any coincident edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        QA <= 1'b0;
    else if (clear)   QA <= 1'b0;
    else if (fall[0]) QA <= ~QA;
  end

  // The QA 1->0 transition is held for one cycle. This is the internal ripple
  // into section B. Clear or reset discards a pending ripple.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ripple <= 1'b0;
    else       ripple <= ~clear & fall[0] & QA;
  end

  assign b_tick = (CASCADE != 0) ? ripple : fall[1];

  // Section B is a modulo-8 counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       cnt_b <= '0;
    else if (clear)  cnt_b <= '0;
    else if (b_tick) cnt_b <= cnt_b + 3'd1;
  end

  assign {QD, QC, QB} = cnt_b;

endmodule

// File: tb/tb_ttl_7493_sync.sv
// Bench for ttl_7493_sync. Three instances are built:
//   dut 0: FILTER=1, CASCADE=0
//   dut 1: FILTER=1, CASCADE=1
//   dut 2: FILTER=3, CASCADE=0
// The stimulus pushes hand-computed expectations {cycle, dut, QD..QA} into a
// scoreboard. A monitor checks each entry at the falling CLK edge of its cycle.
module tb_ttl_7493_sync;

  logic clk = 1'b0;
  int   cyc = 0;

  logic [2:0] rst, cka, ckb, r1, r2;
  logic       qa0, qb0, qc0, qd0;
  logic       qa1, qb1, qc1, qd1;
  logic       qa2, qb2, qc2, qd2;

  typedef struct {
    int         at;
    int         dut;
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  ttl_7493_sync #(.FILTER(1), .CASCADE(0)) u_d0 (
    .CLK(clk), .RESET(rst[0]), .CKA_N(cka[0]), .CKB_N(ckb[0]), .R0_1(r1[0]), .R0_2(r2[0]),
    .QA(qa0), .QB(qb0), .QC(qc0), .QD(qd0));
  ttl_7493_sync #(.FILTER(1), .CASCADE(1)) u_d1 (
    .CLK(clk), .RESET(rst[1]), .CKA_N(cka[1]), .CKB_N(ckb[1]), .R0_1(r1[1]), .R0_2(r2[1]),
    .QA(qa1), .QB(qb1), .QC(qc1), .QD(qd1));
  ttl_7493_sync #(.FILTER(3), .CASCADE(0)) u_d2 (
    .CLK(clk), .RESET(rst[2]), .CKA_N(cka[2]), .CKB_N(ckb[2]), .R0_1(r1[2]), .R0_2(r2[2]),
    .QA(qa2), .QB(qb2), .QC(qc2), .QD(qd2));

  initial forever #5 clk = ~clk;

  // Count rising edges. "cyc == n" means the state just after edge n.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] q_of(input int d);
    case (d)
      0:       return {qd0, qc0, qb0, qa0};
      1:       return {qd1, qc1, qb1, qa1};
      default: return {qd2, qc2, qb2, qa2};
    endcase
  endfunction

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int at, input logic [3:0] e, input string t);
    exp_t x;
    x.at = at; x.dut = d; x.exp = e; x.tag = t;
    sb.push_back(x);
  endtask

  // Monitor. Only this process changes the counters.
  initial forever begin
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        if (q_of(sb[i].dut) !== sb[i].exp) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: got %b expected %b",
                   sb[i].tag, sb[i].dut, cyc, q_of(sb[i].dut), sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: check for cyc %0d was never sampled", sb[i].tag, sb[i].dut, sb[i].at);
        sb.delete(i);
      end
    end
    if (done) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: pending check for cyc %0d at end of run", sb[i].tag, sb[i].dut, sb[i].at);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not reach its end");
    $fatal(1);
  end

  initial begin
    int c;
    logic [3:0] e;
    rst = '1; cka = '1; ckb = '1; r1 = '0; r2 = '0;
    go(2);
    for (int d = 0; d < 3; d++) push(d, cyc, 4'b0000, "reset_state");
    go(1);
    rst = '0;
    go(2);

    // dut0: three CKA_N falls, each held low for 4 CLKs. QA goes 1,0,1.
    e = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      push(0, c + 1, e, "a_before_edge");
      e[0] = ~e[0];
      push(0, c + 2, e, "a_fall_toggle");
      cka[0] = 1'b0; go(4);
      c = cyc;
      push(0, c + 3, e, "a_rise_no_effect");
      cka[0] = 1'b1; go(4);
    end

    // dut0: clear back to zero.
    push(0, cyc + 1, 4'b0000, "clear_basic");
    r1[0] = 1'b1; r2[0] = 1'b1; go(2);
    r1[0] = 1'b0; r2[0] = 1'b0; go(1);

    // dut0: CKA_N and CKB_N fall together. Both sections count.
    c = cyc;
    push(0, c + 1, 4'b0000, "sim_before");
    push(0, c + 2, 4'b0011, "sim_both_count");
    cka[0] = 1'b0; ckb[0] = 1'b0; go(4);
    cka[0] = 1'b1; ckb[0] = 1'b1; go(4);

    // dut0: one more B count gives 0101.
    c = cyc;
    push(0, c + 2, 4'b0101, "b_to_5");
    ckb[0] = 1'b0; go(4);
    ckb[0] = 1'b1; go(4);

    // dut0: clear arrives on the same edge as a CKB_N fall. The edge is lost.
    c = cyc;
    push(0, c + 1, 4'b0101, "clr_pre");
    push(0, c + 2, 4'b0000, "clr_coincident");
    push(0, c + 4, 4'b0000, "clr_hold");
    ckb[0] = 1'b0; go(1);
    r1[0] = 1'b1; r2[0] = 1'b1; go(3);
    push(0, cyc + 3, 4'b0000, "clr_release_no_edge");
    r1[0] = 1'b0; r2[0] = 1'b0; go(4);
    ckb[0] = 1'b1; go(4);

    // dut0: with only R0_1 high, counting is not cleared.
    c = cyc;
    push(0, c + 2, 4'b0001, "a_after_clear");
    cka[0] = 1'b0; go(4);
    cka[0] = 1'b1; go(4);
    c = cyc;
    push(0, c + 1, 4'b0001, "r01_only_hold");
    push(0, c + 2, 4'b0011, "r01_only_counts");
    r1[0] = 1'b1; ckb[0] = 1'b0; go(4);
    r1[0] = 1'b0; ckb[0] = 1'b1; go(4);

    // dut0: clear, then count up to 1010.
    push(0, cyc + 1, 4'b0000, "clear_again");
    r1[0] = 1'b1; r2[0] = 1'b1; go(2);
    r1[0] = 1'b0; r2[0] = 1'b0; go(1);
    for (int i = 1; i <= 5; i++) begin
      push(0, cyc + 2, 4'(i * 2), "b_step");
      ckb[0] = 1'b0; go(3);
      ckb[0] = 1'b1; go(3);
    end

    // dut0: assert reset during a fall with CKA_N held low.
    // The count is recounted FILTER+1 CLKs after release.
    cka[0] = 1'b0; go(1);
    push(0, cyc, 4'b0000, "async_reset");
    rst[0] = 1'b1; go(2);
    c = cyc;
    push(0, c + 1, 4'b0000, "rst_release_1");
    push(0, c + 2, 4'b0001, "rst_release_low_counts");
    rst[0] = 1'b0; go(4);
    cka[0] = 1'b1; go(3);

    // dut1: CKB_N is ignored in cascade mode.
    push(1, cyc + 3, 4'b0000, "ckb_ignored_cascade");
    ckb[1] = 1'b0; go(4);
    ckb[1] = 1'b1; go(3);

    // dut1: 16 CKA_N falls. The B ripple appears one CLK after QA falls.
    for (int i = 1; i <= 16; i++) begin
      c = cyc;
      if (i % 2 == 1) begin
        push(1, c + 2, 4'(i), "casc_odd");
        push(1, c + 3, 4'(i), "casc_odd_hold");
      end else begin
        push(1, c + 2, 4'((i - 1) & 14), "casc_ripple_state");
        push(1, c + 3, 4'(i % 16), "casc_ripple_done");
      end
      cka[1] = 1'b0; go(3);
      cka[1] = 1'b1; go(3);
    end
    push(1, cyc + 1, 4'b0000, "casc_wrap_stable");
    go(2);

    // dut2 (FILTER=3): a 2-CLK low pulse is rejected.
    c = cyc;
    for (int j = 1; j <= 6; j++) push(2, c + j, 4'b0000, "f3_short_low");
    cka[2] = 1'b0; go(2);
    cka[2] = 1'b1; go(6);

    // dut2: a 3-CLK low run toggles QA at edge k+3.
    c = cyc;
    push(2, c + 3, 4'b0000, "f3_pre_toggle");
    push(2, c + 4, 4'b0001, "f3_toggle");
    cka[2] = 1'b0; go(6);

    // dut2: a 2-CLK high glitch while low is rejected, so the return low gives no new fall.
    cka[2] = 1'b1; go(2);
    push(2, cyc + 6, 4'b0001, "f3_short_high");
    cka[2] = 1'b0; go(8);
    cka[2] = 1'b1; go(6);

    for (int k = 0; k < 20 && sb.size() != 0; k++) go(1);
    done = 1'b1;
  end

endmodule
